eth_frame_capture: RTL and testbench

//  Variable-length successor to the fixed-length payload capture stage. Sits between

---
 rtl/eth_frame_capture_if.sv | 30 +++
 rtl/eth_frame_capture.sv | 122 ++++++++++++
 tb/tb_eth_frame_capture.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_frame_capture_if.sv
// eth_frame_capture_if: received byte stream in, payload FIFO write port and frame status out
interface eth_frame_capture_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 11
);
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  rx_byte_valid;
    logic                  capturing;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wr_data;
    logic                  fifo_wr_last;
    logic                  frame_done;
    logic                  frame_error;
    logic [1:0]            err_code;
    logic [LEN_W-1:0]      payload_len;
    logic [31:0]           captured_fcs;

    modport master (
        output rx_byte, rx_byte_valid, capturing, fifo_full,
        input  fifo_wr_en, fifo_wr_data, fifo_wr_last, frame_done, frame_error,
               err_code, payload_len, captured_fcs
    );

    modport slave (
        input  rx_byte, rx_byte_valid, capturing, fifo_full,
        output fifo_wr_en, fifo_wr_data, fifo_wr_last, frame_done, frame_error,
               err_code, payload_len, captured_fcs
    );
endinterface

// File: rtl/eth_frame_capture.sv
// eth_frame_capture: variable-length payload capture, FCS recovered through a delay line
module eth_frame_capture #(
    parameter int DATA_WIDTH  = 8,
    parameter int FCS_BYTES   = 4,
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500,
    parameter int LEN_W       = 11
) (
    input logic               clk,
    input logic               rst,
    eth_frame_capture_if.slave bus
);
    localparam int CW = LEN_W + 1;
    localparam int FW = FCS_BYTES * DATA_WIDTH;
    localparam logic [CW-1:0]    C_FCS  = CW'(FCS_BYTES);
    localparam logic [CW-1:0]    C_LONG = CW'(MAX_PAYLOAD + FCS_BYTES);
    localparam logic [CW-1:0]    C_SAT  = CW'(MAX_PAYLOAD + FCS_BYTES + 1);
    localparam logic [LEN_W-1:0] C_MIN  = LEN_W'(MIN_PAYLOAD);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DROP} state_t;

    state_t                state, state_nxt;
    logic                  cap_d;
    logic                  start, active, acc, eof, pop, is_long, need_wr, ovf, to_drop, wr_c;
    logic [CW-1:0]         cnt;
    logic [FW-1:0]         dl;
    logic [DATA_WIDTH-1:0] pend_d;
    logic                  pend_v;
    logic [1:0]            err_l, err_run, err_fin;
    logic [LEN_W-1:0]      len_c;

    // frame events: byte acceptance, delay-line pop, end of frame and error conditions
    always_comb begin
        active  = state != IDLE;
        start   = bus.capturing & ~cap_d;
        acc     = bus.capturing & bus.rx_byte_valid & (active | start);
        eof     = active & ~bus.capturing;
        pop     = acc & (cnt >= C_FCS);
        is_long = pop & (state != DROP) & (cnt == C_LONG);
        need_wr = pend_v & (state != DROP) & (pop | eof);
        ovf     = need_wr & bus.fifo_full;
        to_drop = ovf | is_long;
        len_c   = cnt > C_FCS ? LEN_W'(cnt - C_FCS) : '0;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next state: end of frame wins, then abort into DROP, then FILL->STREAM on first pop
    always_comb begin
        state_nxt = state == IDLE ? (start ? FILL : IDLE) :
                    eof ? IDLE :
                    to_drop ? DROP :
                    (state == FILL && pop) ? STREAM : state;
    end

    // write strobe and error selection; first error of the frame is kept, short only at end
    always_comb begin
        wr_c    = need_wr & ~bus.fifo_full;
        err_run = err_l != 2'b00 ? err_l : ovf ? 2'b11 : is_long ? 2'b10 : 2'b00;
        err_fin = err_run != 2'b00 ? err_run : len_c < C_MIN ? 2'b01 : 2'b00;
    end

    // delay line, pending byte, saturating byte counter and latched error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_d  <= 1'b1;
            cnt    <= '0;
            dl     <= '0;
            pend_d <= '0;
            pend_v <= 1'b0;
            err_l  <= '0;
        end else begin
            cap_d <= bus.capturing;
            if (eof) begin
                cnt    <= '0;
                dl     <= '0;
                pend_v <= 1'b0;
                err_l  <= '0;
            end else if (acc) begin
                cnt   <= cnt == C_SAT ? cnt : cnt + 1'b1;
                dl    <= {dl[FW-DATA_WIDTH-1:0], bus.rx_byte};
                err_l <= err_run;
                if (pop) begin
                    pend_d <= dl[FW-1 -: DATA_WIDTH];
                    pend_v <= ~to_drop & (state != DROP);
                end
            end
        end
    end

    // registered FIFO write port and end-of-frame status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fifo_wr_en   <= 1'b0;
            bus.fifo_wr_data <= '0;
            bus.fifo_wr_last <= 1'b0;
            bus.frame_done   <= 1'b0;
            bus.frame_error  <= 1'b0;
            bus.err_code     <= '0;
            bus.payload_len  <= '0;
            bus.captured_fcs <= '0;
        end else begin
            bus.fifo_wr_en   <= wr_c;
            bus.fifo_wr_last <= wr_c & eof;
            bus.frame_done   <= eof;
            if (wr_c)
                bus.fifo_wr_data <= pend_d;
            if (eof) begin
                bus.payload_len  <= len_c;
                bus.err_code     <= err_fin;
                bus.frame_error  <= err_fin != 2'b00;
                bus.captured_fcs <= dl;
            end
        end
    end
endmodule

// File: tb/tb_eth_frame_capture.sv
// tb_eth_frame_capture: table-driven frames plus reset and back-to-back sequences
module tb_eth_frame_capture;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eth_frame_capture_if #(.DATA_WIDTH(8), .LEN_W(11)) bus();
    eth_frame_capture #(.MAX_PAYLOAD(100)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          len;
        logic [1:0]  err;
        logic        ferr;
        logic [31:0] fcs;
    } done_t;

    typedef struct {
        int          n;
        logic [7:0]  base;
        bit          gaps;
        int          full_from;
        int          exp_wr;
        bit          exp_last;
        logic [1:0]  exp_err;
        int          exp_len;
        logic [31:0] exp_fcs;
    } vec_t;

    logic [8:0] wr_q[$];
    done_t      done_q[$];
    int         n_chk = 0;
    int         n_fail = 0;

    // record every FIFO write and every frame_done away from the active edge
    always @(negedge clk) begin
        if (bus.fifo_wr_en)
            wr_q.push_back({bus.fifo_wr_last, bus.fifo_wr_data});
        if (bus.frame_done)
            done_q.push_back('{int'(bus.payload_len), bus.err_code, bus.frame_error, bus.captured_fcs});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic v, input logic [7:0] b, input logic f);
        @(posedge clk);
        #1;
        bus.capturing     = c;
        bus.rx_byte_valid = v;
        bus.rx_byte       = b;
        bus.fifo_full     = f;
    endtask

    task automatic send_bytes(input int n, input logic [7:0] base, input bit gaps, input int full_from);
        logic f;
        for (int i = 0; i < n; i++) begin
            f = full_from >= 0 && i >= full_from;
            if (gaps)
                repeat ($urandom_range(0, 2)) drive(1'b1, 1'b0, 8'hEE, f);
            drive(1'b1, 1'b1, base + 8'(i), f);
        end
    endtask

    // end cycle carries a valid junk byte that must be ignored
    task automatic end_frame();
        drive(1'b0, 1'b1, 8'hEE, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        bit ok;
        int nlast, lastpos;
        wr_q.delete();
        done_q.delete();
        send_bytes(v.n, v.base, v.gaps, v.full_from);
        end_frame();
        chk($sformatf("v%0d writes", idx), wr_q.size(), v.exp_wr);
        ok = 1'b1;
        nlast = 0;
        lastpos = -1;
        for (int k = 0; k < wr_q.size(); k++) begin
            if (wr_q[k][7:0] !== v.base + 8'(k))
                ok = 1'b0;
            if (wr_q[k][8]) begin
                nlast++;
                lastpos = k;
            end
        end
        chk($sformatf("v%0d data order", idx), ok, 1);
        chk($sformatf("v%0d last count", idx), nlast, v.exp_last ? 1 : 0);
        chk($sformatf("v%0d last pos", idx), lastpos, v.exp_last ? v.exp_wr - 1 : -1);
        chk($sformatf("v%0d frame_done", idx), done_q.size(), 1);
        if (done_q.size() > 0) begin
            chk($sformatf("v%0d err_code", idx), done_q[0].err, v.exp_err);
            chk($sformatf("v%0d frame_error", idx), done_q[0].ferr, v.exp_err != 2'b00);
            chk($sformatf("v%0d payload_len", idx), done_q[0].len, v.exp_len);
            chk($sformatf("v%0d captured_fcs", idx), done_q[0].fcs, v.exp_fcs);
        end
    endtask

    initial begin
        vec_t vt[10];
        bit   ok;
        int   nlast;
        vt[0] = '{68,  8'h10, 1'b0, -1, 64,  1'b1, 2'b00, 64,  32'h50515253};
        vt[1] = '{50,  8'h20, 1'b1, -1, 46,  1'b1, 2'b00, 46,  32'h4E4F5051};
        vt[2] = '{14,  8'h30, 1'b0, -1, 10,  1'b1, 2'b01, 10,  32'h3A3B3C3D};
        vt[3] = '{124, 8'h00, 1'b0, -1, 100, 1'b0, 2'b10, 101, 32'h78797A7B};
        vt[4] = '{68,  8'h40, 1'b0, 24, 19,  1'b0, 2'b11, 64,  32'h80818283};
        vt[5] = '{3,   8'hB0, 1'b0, -1, 0,   1'b0, 2'b01, 0,   32'h00B0B1B2};
        vt[6] = '{5,   8'h60, 1'b0, -1, 1,   1'b1, 2'b01, 1,   32'h61626364};
        vt[7] = '{4,   8'h70, 1'b0, -1, 0,   1'b0, 2'b01, 0,   32'h70717273};
        vt[8] = '{104, 8'h00, 1'b0, -1, 100, 1'b1, 2'b00, 100, 32'h64656667};
        vt[9] = '{105, 8'h00, 1'b0, -1, 100, 1'b0, 2'b10, 101, 32'h65666768};

        rst               = 1'b1;
        bus.capturing     = 1'b1;
        bus.rx_byte_valid = 1'b0;
        bus.rx_byte       = 8'h00;
        bus.fifo_full     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset fifo_wr_en", bus.fifo_wr_en, 0);
        chk("reset frame_done", bus.frame_done, 0);
        chk("reset payload_len", bus.payload_len, 0);
        chk("reset err_code", bus.err_code, 0);
        chk("reset captured_fcs", bus.captured_fcs, 0);
        rst = 1'b0;

        // capturing already high at reset release: no frame until a fresh rise
        send_bytes(12, 8'hA0, 1'b0, -1);
        end_frame();
        chk("pre-high writes", wr_q.size(), 0);
        chk("pre-high frame_done", done_q.size(), 0);

        for (int i = 0; i < 10; i++)
            run_vector(vt[i], i);

        // reset in the middle of a frame, capturing kept high afterwards
        wr_q.delete();
        done_q.delete();
        send_bytes(30, 8'hC0, 1'b0, -1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst fifo_wr_en", bus.fifo_wr_en, 0);
        chk("midrst payload_len", bus.payload_len, 0);
        chk("midrst err_code", bus.err_code, 0);
        chk("midrst frame_error", bus.frame_error, 0);
        chk("midrst captured_fcs", bus.captured_fcs, 0);
        wr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_bytes(10, 8'hD0, 1'b0, -1);
        end_frame();
        chk("midrst writes after", wr_q.size(), 0);
        chk("midrst frame_done", done_q.size(), 0);
        run_vector(vt[0], 10);

        // two frames separated by a single idle cycle
        wr_q.delete();
        done_q.delete();
        send_bytes(52, 8'h01, 1'b0, -1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        send_bytes(50, 8'h90, 1'b0, -1);
        end_frame();
        chk("b2b writes", wr_q.size(), 94);
        ok = 1'b1;
        nlast = 0;
        for (int k = 0; k < wr_q.size(); k++) begin
            if (wr_q[k][7:0] !== (k < 48 ? 8'h01 + 8'(k) : 8'h90 + 8'(k - 48)))
                ok = 1'b0;
            if (wr_q[k][8] && k != 47 && k != 93)
                ok = 1'b0;
            if (wr_q[k][8])
                nlast++;
        end
        chk("b2b data order", ok, 1);
        chk("b2b last count", nlast, 2);
        chk("b2b frame_done", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk("b2b len A", done_q[0].len, 48);
            chk("b2b len B", done_q[1].len, 46);
            chk("b2b err A", done_q[0].err, 0);
            chk("b2b err B", done_q[1].err, 0);
            chk("b2b fcs A", done_q[0].fcs, 32'h31323334);
            chk("b2b fcs B", done_q[1].fcs, 32'hBEBFC0C1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
